// File: rtl/pipelined_addsub.sv
// pipelined_addsub: valid/ready add/subtract whose carry chain is split into
// STAGES registered segments behind an input register (STAGES+1 beats in flight).
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);
  localparam int SEG = WIDTH / STAGES;

  logic              adv;
  logic [STAGES:0]   v_q, v_d;
  logic              c_q [STAGES+1];
  logic              c_d [STAGES+1];
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  r_q [1:STAGES];
  logic [WIDTH-1:0]  r_d [1:STAGES];
  logic              ovf_q, ovf_d;

  // One global enable: a held result freezes every stage, bubbles included.
  assign adv      = !v_q[STAGES] || out_ready;
  assign in_ready = adv;
  assign v_d      = {v_q[STAGES-1:0], in_valid};

  // p0 holds the raw operands; c_q[0] carries sub into stage 1 as carry-in.
  assign a_d[0] = x;
  assign b_d[0] = y;
  assign c_d[0] = sub;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, r_in;
    logic [SEG-1:0]   a_seg, b_seg;
    logic [SEG:0]     sum;

    if (k == 1) begin : g_first
      assign b_in = c_q[0] ? ~b_q[0] : b_q[0];
      assign r_in = '0;
    end else begin : g_rest
      assign b_in = b_q[k-1];
      assign r_in = r_q[k-1];
    end

    assign a_in  = a_q[k-1];
    assign a_seg = SEG'(a_in >> ((k-1) * SEG));
    assign b_seg = SEG'(b_in >> ((k-1) * SEG));
    assign sum   = {1'b0, a_seg} + {1'b0, b_seg} + (SEG+1)'(c_q[k-1]);

    // Lower result bits are already final and the upper bits of r_in are zero.
    assign r_d[k] = r_in | (WIDTH'(sum[SEG-1:0]) << ((k-1) * SEG));
    assign c_d[k] = sum[SEG];

    if (k < STAGES) begin : g_skew
      assign a_d[k] = a_in;
      assign b_d[k] = b_in;
    end else begin : g_last
      assign ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[SEG-1] != a_in[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared too, so out/carry_out/overflow read 0 after reset.
      v_q   <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int i = 0; i <= STAGES; i++) c_q[i] <= 1'b0;
      for (int i = 1; i <= STAGES; i++) r_q[i] <= '0;
    end else if (adv) begin
      v_q   <= v_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
      end
      for (int i = 0; i <= STAGES; i++) c_q[i] <= c_d[i];
      for (int i = 1; i <= STAGES; i++) r_q[i] <= r_d[i];
    end
  end

  assign out_valid = v_q[STAGES];
  assign out       = r_q[STAGES];
  assign carry_out = c_q[STAGES];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: 32-bit/2-stage instance driven with directed and
// random beats against an arithmetic scoreboard, plus a 64-bit/4-stage instance.
module tb_pipelined_addsub;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_sub, a_out_valid, a_out_ready, a_carry, a_ovf;
  logic [31:0] a_x, a_y, a_out;

  logic        b_in_valid, b_in_ready, b_sub, b_out_valid, b_out_ready, b_carry, b_ovf;
  logic [63:0] b_x, b_y, b_out;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  pipelined_addsub #(.WIDTH(32), .STAGES(2)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .sub(a_sub),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out(a_out), .carry_out(a_carry), .overflow(a_ovf)
  );

  pipelined_addsub #(.WIDTH(64), .STAGES(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .sub(b_sub),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out(b_out), .carry_out(b_carry), .overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned view gives result and carry (no borrow = x >= y),
  // signed view gives overflow as "true result outside the w-bit range".
  function automatic void model(input logic [63:0] x, input logic [63:0] y, input logic s,
                                input int w, output logic [63:0] r, output logic c,
                                output logic v);
    logic [127:0]        ux, uy, ures;
    logic signed [127:0] sx, sy, sres, lim;
    logic [63:0]         mask;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ux   = {64'd0, x & mask};
    uy   = {64'd0, y & mask};
    ures = s ? (ux - uy) : (ux + uy);
    r    = ures[63:0] & mask;
    c    = s ? (ux >= uy) : ((ures >> w) != 128'd0);
    sx   = $signed(ux);
    sy   = $signed(uy);
    if (x[w-1]) sx = sx - (128'sd1 <<< w);
    if (y[w-1]) sy = sy - (128'sd1 <<< w);
    sres = s ? (sx - sy) : (sx + sy);
    lim  = 128'sd1 <<< (w - 1);
    v    = (sres >= lim) || (sres < -lim);
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic s);
    a_in_valid = 1'b1;
    a_x        = x;
    a_y        = y;
    a_sub      = s;
  endtask

  // One clock of the 32-bit port: score handshakes at the falling edge, then
  // advance to just after the rising edge so the caller can drive new inputs.
  task automatic tick();
    exp_t        e;
    logic [63:0] r;
    logic        c, v;
    @(negedge clk);
    if (a_out_valid && a_out_ready) begin
      if (q.size() == 0) begin
        check_bit("spurious_out", a_out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check_vec("out", {32'd0, a_out}, {32'd0, e.r});
        check_bit("carry_out", a_carry, e.c);
        check_bit("overflow", a_ovf, e.v);
      end
    end
    if (a_in_valid && a_in_ready) begin
      model({32'd0, a_x}, {32'd0, a_y}, a_sub, 32, r, c, v);
      e.r = r[31:0];
      e.c = c;
      e.v = v;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    check_vec("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick32();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_0000};
    return ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
  endfunction

  initial begin
    logic [63:0] vx [4];
    logic [63:0] vy [4];
    logic        vs [4];
    logic [63:0] r;
    logic        c, v;
    logic [31:0] held;

    rst_n = 1'b0;
    a_in_valid = 1'b1; a_x = 32'h1234_5678; a_y = 32'h9ABC_DEF0; a_sub = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_x = '0; b_y = '0; b_sub = 1'b0; b_out_ready = 1'b1;

    // Reset held two edges with a beat offered.
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_out_valid", a_out_valid, 1'b0);
    check_vec("rst_out", {32'd0, a_out}, 64'd0);
    check_bit("rst_carry", a_carry, 1'b0);
    check_bit("rst_ovf", a_ovf, 1'b0);
    check_bit("rst_in_ready", a_in_ready, 1'b1);
    check_bit("rst_out_valid64", b_out_valid, 1'b0);
    rst_n = 1'b1;
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("post_rst_idle", a_out_valid, 1'b0);
    end

    // Streaming add with latency check: first result valid after the third edge.
    drive(32'h1, 32'h2, 1'b0);          tick();
    check_bit("lat_edge1", a_out_valid, 1'b0);
    drive(32'hFFFF_FFFF, 32'h1, 1'b0);  tick();
    check_bit("lat_edge2", a_out_valid, 1'b0);
    drive(32'h7FFF_FFFF, 32'h1, 1'b0);  tick();
    check_bit("lat_edge3", a_out_valid, 1'b1);
    check_vec("first_sum", {32'd0, a_out}, 64'd3);
    drain();

    // Subtract, including borrow and signed overflow.
    drive(32'd5, 32'd7, 1'b1);          tick();
    drive(32'h8000_0000, 32'h1, 1'b1);  tick();
    drain();

    // Backpressure: fill three beats, stall five cycles with a fourth offered.
    a_out_ready = 1'b0;
    drive(32'h0000_0010, 32'h0000_0020, 1'b0); tick();
    drive(32'h0000_0100, 32'h0000_0001, 1'b1); tick();
    drive(32'hF000_0000, 32'h1000_0000, 1'b0); tick();
    drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    held = q[0].r;
    for (int i = 0; i < 5; i++) begin
      check_bit("stall_in_ready", a_in_ready, 1'b0);
      check_bit("stall_out_valid", a_out_valid, 1'b1);
      check_vec("stall_out_held", {32'd0, a_out}, {32'd0, held});
      tick();
    end
    check_vec("stall_depth", 64'(q.size()), 64'd3);
    a_out_ready = 1'b1;
    tick();
    check_vec("release_accept", 64'(q.size()), 64'd3);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_x         = pick32();
      a_y         = pick32();
      a_sub       = 1'($urandom_range(0, 1));
      a_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset with two beats in flight: both must vanish.
    drive(32'h11, 32'h22, 1'b0); tick();
    drive(32'h33, 32'h44, 1'b1); tick();
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    check_bit("midrst_out_valid", a_out_valid, 1'b0);
    check_bit("midrst_in_ready", a_in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_bit("midrst_no_emerge", a_out_valid, 1'b0);
    end

    // 64-bit, 4-stage: carries crossing segment boundaries, latency of five edges.
    vx = '{64'h0000_FFFF_FFFF_FFFF, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, {$urandom, $urandom}};
    vy = '{64'h1, 64'h1, 64'h1, {$urandom, $urandom}};
    vs = '{1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1))};
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_x = vx[i];
      b_y = vy[i];
      b_sub = vs[i];
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_bit("w64_lat_early", b_out_valid, 1'b0);
      @(posedge clk);
      #1;
      model(vx[i], vy[i], vs[i], 64, r, c, v);
      check_bit("w64_valid", b_out_valid, 1'b1);
      check_vec("w64_out", b_out, r);
      check_bit("w64_carry", b_carry, c);
      check_bit("w64_ovf", b_ovf, v);
      if (i == 0) check_vec("w64_cross_seg", b_out, 64'h0001_0000_0000_0000);
    end
    @(posedge clk);
    #1;
    check_bit("w64_consumed", b_out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, valid/ready-handshaked successor to the fixed two-register 32-bit adder pipeline. Adds or subtracts two WIDTH-bit operands and splits the carry chain across STAGES register stages so wide adders close timing. Supports backpressure and reports carry-out and signed overflow. Instantiated in the generated datapath wherever a multi-cycle add/sub with flow control is needed.

## Interface

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES
- STAGES, 2, carry-chain segments (1..8); segment width SEG = WIDTH/STAGES

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  operand beat offered
- in_ready  output  1  block accepts a beat this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- sub  input  1  0: x+y, 1: x-y (two's complement), captured with the beat
- out_valid  output  1  result beat present
- out_ready  input  1  consumer takes result this cycle
- out  output  WIDTH  result, modulo 2^WIDTH
- carry_out  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow of the operation

## Operation

- Pipeline: input register (p0) then STAGES segment registers (p1..pSTAGES); pSTAGES drives outputs directly.
- p0 captures x, y, sub, valid. Effective B = sub ? ~y : y; carry-in = sub.
- Stage k (1..STAGES) adds segment k-1 (bits [k*SEG-1:(k-1)*SEG]) of A and effective B with the carry registered from stage k-1 (stage 1 uses carry-in); stores SEG result bits, the new carry, and passes the not-yet-added upper segments of A/B and already-computed lower result bits forward (skew registers).
- Final stage: carry_out = carry from top segment; overflow = (A[MSB] == Beff[MSB]) && (out[MSB] != A[MSB]).
- Flow control is a global enable: adv = !out_valid || out_ready. All stage registers (data and valid) load only when adv = 1; otherwise hold. in_ready = adv (combinational, no dependence on in_valid).
- A beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- Bubbles: a stage whose valid bit is 0 still advances when adv = 1; bubbles are not collapsed when adv = 0.
- Data registers of invalid stages are don't-care but deterministic (they load whatever is upstream).
- Reset (rst_n = 0 at a clock edge): all valid bits and all data registers cleared to 0, regardless of adv. Beats in flight are discarded. During and after reset: out_valid = 0, out = 0, carry_out = 0, overflow = 0, in_ready = 1.

## Timing

- Latency: beat accepted at edge N appears with out_valid = 1 after edge N+STAGES+1 when no stall (STAGES=2: 3 cycles, one more than the unpipelined-carry predecessor).
- Throughput: one beat per cycle while out_ready = 1 is held.
- Capacity: STAGES+1 beats in flight.
- Stall: out_valid && !out_ready freezes the whole pipeline; out/carry_out/overflow stay stable; in_ready = 0 the same cycle.
- out_ready asserted with out_valid = 0: no effect other than adv = 1 (already 1).
- Simultaneous consume and accept in one cycle are allowed with no bubble.
- rst_n has priority over adv and in_valid.

## Test plan

- Reset: rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, out = 0, in_ready = 1; no beat emerges after release.
- Streaming add, WIDTH=32 STAGES=2, out_ready = 1: beats (1,2), (0xFFFFFFFF,1), (0x7FFFFFFF,1) on consecutive cycles -> 3 cycles later consecutive results 3/c0/v0, 0x00000000/c1/v0, 0x80000000/c0/v1.
- Subtract: (5,7,sub=1) -> out = 0xFFFFFFFE, carry_out = 0; (0x80000000,1,sub=1) -> 0x7FFFFFFF, carry_out = 1, overflow = 1.
- Backpressure: fill with 3 beats, hold out_ready = 0 for 5 cycles -> in_ready = 0, out frozen on first result; release -> 3 results in order, no loss/duplication.
- Cross-segment carry, WIDTH=64 STAGES=4: x = 0x0000FFFFFFFFFFFF, y = 1 -> out = 0x0001000000000000 after 5 cycles.
- Reset mid-flight: 2 beats in pipeline, rst_n = 0 one cycle -> out_valid = 0 next cycle, neither beat ever emerges.
